// File: rtl/stream_phase_decoder_if.sv
// Valid/ready word stream with a phase-0 sync marker, shared by the encoded
// input and the decoded output of stream_phase_decoder.
interface stream_phase_decoder_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  logic             sync;

  modport master (output valid, output data, output sync, input ready);
  modport slave  (input valid, input data, input sync, output ready);
endinterface

// File: rtl/stream_phase_decoder.sv
// Receive side of the phase-inverting word encoder: phase tracking, sync lock,
// decode and a 2-entry output buffer. Macro STREAM_PHASE_DECODER_STATS_EN adds word_cnt.
module stream_phase_decoder #(
  parameter int WIDTH      = 32,
  parameter int PHASE_BITS = 3,
  parameter int PASS_PHASE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  stream_phase_decoder_if.slave  i_in,
  stream_phase_decoder_if.master o_out,
  output logic                  o_locked,
  output logic [PHASE_BITS-1:0] o_phase,
  output logic [15:0]           o_err_cnt,
  output logic [31:0]           o_word_cnt
);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t                r_state, w_state_nxt;
  logic [PHASE_BITS-1:0] r_phase, w_phase_nxt, w_apply_phase;
  logic [15:0]           r_err_cnt;
  logic [WIDTH-1:0]      r_head_data, r_tail_data, w_dec_data;
  logic                  r_head_valid, r_tail_valid;
  logic                  w_in_ready, w_accept, w_push, w_pop, w_err;

  // Full only when the tail slot is occupied; pop readiness is deliberately ignored.
  assign w_in_ready = (r_state == UNLOCKED) ? 1'b1 : !r_tail_valid;
  assign w_accept   = i_in.valid && w_in_ready;
  assign w_pop      = r_head_valid && o_out.ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_phase_nxt   = r_phase;
    w_apply_phase = r_phase;
    w_push        = 1'b0;
    w_err         = 1'b0;
    case (r_state)
      UNLOCKED: begin
        if (w_accept && i_in.sync) begin
          w_push        = 1'b1;
          w_apply_phase = '0;
          w_phase_nxt   = PHASE_BITS'(1);
          w_state_nxt   = LOCKED;
        end
      end
      LOCKED: begin
        if (w_accept) begin
          w_push = 1'b1;
          if (i_in.sync) begin
            w_apply_phase = '0;
            w_phase_nxt   = PHASE_BITS'(1);
            w_err         = (r_phase != '0);
          end else begin
            w_phase_nxt = r_phase + PHASE_BITS'(1);
          end
        end
      end
      default: w_state_nxt = UNLOCKED;
    endcase
  end

  assign w_dec_data = (w_apply_phase == PHASE_BITS'(PASS_PHASE)) ? i_in.data : ~i_in.data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= UNLOCKED;
      r_phase   <= '0;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      if (w_err && r_err_cnt != 16'hFFFF)
        r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  // Head register is the output itself; tail only fills when head is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head_data  <= '0;
      r_head_valid <= 1'b0;
      r_tail_data  <= '0;
      r_tail_valid <= 1'b0;
    end else if (w_pop) begin
      if (r_tail_valid) begin
        r_head_data  <= r_tail_data;
        r_tail_valid <= w_push;
        if (w_push)
          r_tail_data <= w_dec_data;
      end else if (w_push) begin
        r_head_data <= w_dec_data;
      end else begin
        r_head_valid <= 1'b0;
      end
    end else if (w_push) begin
      if (!r_head_valid) begin
        r_head_data  <= w_dec_data;
        r_head_valid <= 1'b1;
      end else begin
        r_tail_data  <= w_dec_data;
        r_tail_valid <= 1'b1;
      end
    end
  end

`ifdef STREAM_PHASE_DECODER_STATS_EN
  logic [31:0] r_word_cnt;
  always_ff @(posedge clk) begin
    if (rst)
      r_word_cnt <= '0;
    else if (w_pop)
      r_word_cnt <= r_word_cnt + 32'd1;
  end
  assign o_word_cnt = r_word_cnt;
`else
  assign o_word_cnt = '0;
`endif

  assign i_in.ready  = w_in_ready;
  assign o_out.valid = r_head_valid;
  assign o_out.data  = r_head_data;
  assign o_out.sync  = 1'b0;
  assign o_locked    = (r_state == LOCKED);
  assign o_phase     = r_phase;
  assign o_err_cnt   = r_err_cnt;

endmodule

// File: doc/stream_phase_decoder.md
Name: stream_phase_decoder

Overview:
- Receive end of the phase-inverting word encoder.
- The encoder sends raw data on its pass phase (phase 1 of an 8-phase cycle) and bitwise-inverted data on every other phase.
- This block tracks the same phase, aligns to it with a sync marker, and recovers the original words.
- Decoded words go through a 2-entry output buffer with valid/ready on both sides; an error counter records phase-misalignment events for coverage and debug.

Parameters:
- WIDTH, 32, data word width.
- PHASE_BITS, 3, phase counter width; phase wraps at 2^PHASE_BITS.
- PASS_PHASE, 1, phase on which data is sent uninverted.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  encoded word present.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  WIDTH  encoded word.
- in_sync  input  1  marks the current input word as phase 0.
- out_valid  output  1  decoded word available.
- out_ready  input  1  downstream accepts the word.
- out_data  output  WIDTH  decoded word.
- locked  output  1  phase alignment established.
- phase  output  PHASE_BITS  phase that will be applied to the next accepted word.
- err_cnt  output  16  saturating count of resync errors.
- word_cnt  output  32  decoded-word counter (see Optional Feature).

Behaviour:
- Accept condition: a word is accepted when in_valid && in_ready in the same cycle.
- Reset (rst=1 at posedge):
  - state=UNLOCKED, phase=0, buffer emptied, out_valid=0, out_data=0, locked=0, err_cnt=0, word_cnt=0.
  - Reset mid-operation discards buffered words with no output handshake.
- State UNLOCKED:
  - in_ready=1.
  - Accepted words without in_sync are dropped; phase is not advanced.
  - Accepted word with in_sync: decode it with phase 0, push it to the buffer, set phase=1, go to LOCKED.
- State LOCKED:
  - in_ready = buffer not full.
  - Word accepted without in_sync: decode with the current phase, push it, then phase = phase+1 mod 2^PHASE_BITS. Wrap goes 7 -> 0 at default width.
  - Word accepted with in_sync while phase==0: normal decode, no error.
  - Word accepted with in_sync while phase!=0: resync error.
    - err_cnt increments, saturating at 16'hFFFF.
    - The word is decoded with phase 0 and pushed; phase is set to 1.
    - State remains LOCKED.
- locked is 1 exactly in LOCKED state.
- Decode rule: out word = in_data if the applied phase == PASS_PHASE, else ~in_data.
- Buffer:
  - 2-entry FIFO; head drives out_data, out_valid = not empty.
  - Latency: a word accepted at edge N appears on out_valid/out_data after edge N if the buffer was empty, i.e. 1 cycle.
  - Simultaneous push and pop is allowed in any fill state where in_ready=1; occupancy is unchanged.
  - Full (2 entries): in_ready=0 in LOCKED even if out_ready=1 that cycle (no combinational ready path).
  - Empty: out_data holds the last popped value (0 after reset) and out_valid=0.
  - Words are never dropped or reordered once pushed.
- out_data must remain stable while out_valid=1 and out_ready=0.
- All outputs are registered except in_ready, which is combinational from state and buffer occupancy only.

Optional Feature:
- Macro: STREAM_PHASE_DECODER_STATS_EN.
- Defined: word_cnt is a 32-bit counter.
  - Increments on every output handshake (out_valid && out_ready) and wraps at 2^32.
  - Reset to 0.
- Undefined: word_cnt is tied to 0 and no counter logic is synthesised; all other behaviour is identical.

Test Plan:
- Reset then unlocked drop:
  - Stimulus: rst 2 cycles; send in_data=32'h12345678, 3 words, in_sync=0.
  - Response: in_ready=1, out_valid stays 0, locked=0, phase=0.
- Lock and decode a full phase cycle:
  - Stimulus: 8 words; the first has in_sync=1. Word at phase 1 is A=32'hDEADBEEF; every other phase sends ~A=32'h21524110. out_ready=1.
  - Response: 8 outputs, all 32'hDEADBEEF; locked=1; phase wraps back to 0.
- Backpressure:
  - Stimulus: locked, out_ready=0, 3 words offered.
  - Response: 2 accepted, then in_ready=0.
  - Stimulus continued: raise out_ready.
  - Response: outputs in order, out_data stable while stalled, third word accepted after a slot frees.
- Resync error:
  - Stimulus: locked at phase 3, word with in_sync=1.
  - Response: err_cnt 0 -> 1, the word is inverted (phase 0 decode), phase=1 afterwards.
  - Stimulus continued: sync at phase 0.
  - Response: err_cnt unchanged.
- Reset mid-stream:
  - Stimulus: 2 words buffered, assert rst.
  - Response: next cycle out_valid=0, locked=0, err_cnt=0, and no buffered word emerges after rst drops.
- Stats (macro defined):
  - Stimulus: 5 output handshakes.
  - Response: word_cnt=5.
  - Macro undefined: word_cnt=0 throughout.
